// File: rtl/instr_register_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Package : instr_register_pkg                                               |
// | Purpose : Shared types for the instruction register and its execute stage: |
// |           opcodes, operands, packed instruction words, addresses, counts,  |
// |           result type and the execute-stage state encoding.               |
// | Revision: 1.0  - initial release                                           |
// +----------------------------------------------------------------------------+
package instr_register_pkg;

  localparam int OPERAND_W     = 32;
  localparam int ADDR_W        = 5;
  localparam int COUNT_W       = 6;
  localparam int EXEC_RESULT_W = 64;

  // The register holds 32 locations, so a window never exceeds 32 entries.
  localparam logic [COUNT_W-1:0] MAX_COUNT = 6'd32;

  typedef enum logic [2:0] {
    ZERO  = 3'd0,
    PASSA = 3'd1,
    PASSB = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    MULT  = 3'd5,
    DIV   = 3'd6,
    MOD   = 3'd7
  } opcode_t;

  typedef logic signed [OPERAND_W-1:0]     operand_t;
  typedef logic        [ADDR_W-1:0]        address_t;
  typedef logic        [COUNT_W-1:0]       count_t;
  typedef logic signed [EXEC_RESULT_W-1:0] result_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    OUT   = 3'd3,
    FIN   = 3'd4
  } exec_state_t;

endpackage : instr_register_pkg
`default_nettype wire

// File: rtl/instr_alu.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module  : instr_alu                                                        |
// | Purpose : Purely combinational arithmetic for one instruction. Operands    |
// |           are sign-extended to RESULT_W before any operation, so MULT      |
// |           yields the full product.                                         |
// | Ports   : opcode_i      - operation select                                 |
// |           op_a_i/op_b_i - signed operands                                  |
// |           result_o      - signed RESULT_W result                           |
// |           div_by_zero_o - DIV/MOD attempted with op_b == 0                 |
// | Revision: 1.0  - initial release                                           |
// +----------------------------------------------------------------------------+
module instr_alu
  import instr_register_pkg::*;
#(
  parameter int                         RESULT_W    = EXEC_RESULT_W,
  parameter logic signed [RESULT_W-1:0] DIV0_RESULT = '0
) (
  input  opcode_t                     opcode_i,
  input  operand_t                    op_a_i,
  input  operand_t                    op_b_i,
  output logic signed [RESULT_W-1:0]  result_o,
  output logic                        div_by_zero_o
);

  logic signed [RESULT_W-1:0] w_a;
  logic signed [RESULT_W-1:0] w_b;
  logic                       w_b_zero;

  assign w_a      = {{(RESULT_W-OPERAND_W){op_a_i[OPERAND_W-1]}}, op_a_i};
  assign w_b      = {{(RESULT_W-OPERAND_W){op_b_i[OPERAND_W-1]}}, op_b_i};
  assign w_b_zero = (op_b_i == '0);

  // Signed '/' truncates toward zero and signed '%' follows the dividend's
  // sign, which is exactly the required DIV/MOD semantics.
  always_comb begin
    result_o      = '0;
    div_by_zero_o = 1'b0;
    unique case (opcode_i)
      ZERO:  result_o = '0;
      PASSA: result_o = w_a;
      PASSB: result_o = w_b;
      ADD:   result_o = w_a + w_b;
      SUB:   result_o = w_a - w_b;
      MULT:  result_o = w_a * w_b;
      DIV: begin
        if (w_b_zero) begin
          result_o      = DIV0_RESULT;
          div_by_zero_o = 1'b1;
        end else begin
          result_o = w_a / w_b;
        end
      end
      MOD: begin
        if (w_b_zero) begin
          result_o      = DIV0_RESULT;
          div_by_zero_o = 1'b1;
        end else begin
          result_o = w_a % w_b;
        end
      end
      default: result_o = '0;
    endcase
  end

endmodule : instr_alu
`default_nettype wire

// File: rtl/instr_exec_unit.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module  : instr_exec_unit                                                  |
// | Purpose : Execute stage. On start, walks read_pointer across a window of   |
// |           the instruction register, captures each word, evaluates it and   |
// |           presents the result on a valid/ready channel.                    |
// | Ports   : clk, reset        - clock, synchronous active-high reset         |
// |           start             - launch pulse (ignored unless idle)           |
// |           base_addr, count  - window start and length (clamped to 32)      |
// |           read_pointer      - address to the instruction register          |
// |           instruction_word  - combinational read data at read_pointer      |
// |           res_valid/ready   - result handshake                             |
// |           result, res_opcode, res_addr, div_by_zero - result payload       |
// |           busy              - high whenever not idle                       |
// |           done              - one-cycle pulse at window completion         |
// | Revision: 1.0  - initial release                                           |
// +----------------------------------------------------------------------------+
module instr_exec_unit
  import instr_register_pkg::*;
#(
  parameter int                         RESULT_W    = EXEC_RESULT_W,
  parameter logic signed [RESULT_W-1:0] DIV0_RESULT = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  address_t                    base_addr,
  input  count_t                      count,
  output address_t                    read_pointer,
  input  instruction_t                instruction_word,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic signed [RESULT_W-1:0]  result,
  output opcode_t                     res_opcode,
  output address_t                    res_addr,
  output logic                        div_by_zero,
  output logic                        busy,
  output logic                        done
);

  localparam address_t c_RPTR_RST = 5'h1F;

  exec_state_t                state_q,     state_d;
  address_t                   rptr_q,      rptr_d;
  count_t                     remaining_q, remaining_d;
  instruction_t               cap_instr_q, cap_instr_d;
  address_t                   cap_addr_q,  cap_addr_d;
  logic                       res_valid_q, res_valid_d;
  logic signed [RESULT_W-1:0] result_q,    result_d;
  opcode_t                    res_opc_q,   res_opc_d;
  address_t                   res_addr_q,  res_addr_d;
  logic                       dbz_q,       dbz_d;

  logic signed [RESULT_W-1:0] w_alu_result;
  logic                       w_alu_dbz;

  instr_alu #(
    .RESULT_W    (RESULT_W),
    .DIV0_RESULT (DIV0_RESULT)
  ) u_alu (
    .opcode_i      (cap_instr_q.opc),
    .op_a_i        (cap_instr_q.op_a),
    .op_b_i        (cap_instr_q.op_b),
    .result_o      (w_alu_result),
    .div_by_zero_o (w_alu_dbz)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rptr_q      <= c_RPTR_RST;
      remaining_q <= '0;
      cap_instr_q <= '0;
      cap_addr_q  <= '0;
      res_valid_q <= 1'b0;
      result_q    <= '0;
      res_opc_q   <= ZERO;
      res_addr_q  <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rptr_q      <= rptr_d;
      remaining_q <= remaining_d;
      cap_instr_q <= cap_instr_d;
      cap_addr_q  <= cap_addr_d;
      res_valid_q <= res_valid_d;
      result_q    <= result_d;
      res_opc_q   <= res_opc_d;
      res_addr_q  <= res_addr_d;
      dbz_q       <= dbz_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rptr_d      = rptr_q;
    remaining_d = remaining_q;
    cap_instr_d = cap_instr_q;
    cap_addr_d  = cap_addr_q;
    res_valid_d = res_valid_q;
    result_d    = result_q;
    res_opc_d   = res_opc_q;
    res_addr_d  = res_addr_q;
    dbz_d       = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          remaining_d = (count > MAX_COUNT) ? MAX_COUNT : count;
          rptr_d      = base_addr;
          state_d     = (count == '0) ? FIN : FETCH;
        end
      end
      FETCH: begin
        // read_pointer settled on the previous edge, so the register's
        // combinational read data is valid now.
        cap_instr_d = instruction_word;
        cap_addr_d  = rptr_q;
        state_d     = EXEC;
      end
      EXEC: begin
        result_d    = w_alu_result;
        res_opc_d   = cap_instr_q.opc;
        res_addr_d  = cap_addr_q;
        dbz_d       = w_alu_dbz;
        res_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        // res_valid is always set in OUT, so ready alone completes the handshake.
        if (res_ready) begin
          res_valid_d = 1'b0;
          remaining_d = remaining_q - 6'd1;
          if (remaining_q == 6'd1) begin
            state_d = FIN;
          end else begin
            rptr_d  = rptr_q + 5'd1;  // 31 wraps naturally to 0
            state_d = FETCH;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign read_pointer = rptr_q;
  assign res_valid    = res_valid_q;
  assign result       = result_q;
  assign res_opcode   = res_opc_q;
  assign res_addr     = res_addr_q;
  assign div_by_zero  = dbz_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == FIN);

endmodule : instr_exec_unit
`default_nettype wire

// File: tb/tb_instr_exec_unit.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module  : tb_instr_exec_unit                                               |
// | Purpose : Scoreboard bench for instr_exec_unit with a behavioural          |
// |           instruction register model.                                      |
// | Revision: 1.0  - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_instr_exec_unit;
  import instr_register_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  address_t           base_addr;
  count_t             count;
  address_t           read_pointer;
  instruction_t       instruction_word;
  logic               res_valid;
  logic               res_ready;
  logic signed [63:0] result;
  opcode_t            res_opcode;
  address_t           res_addr;
  logic               div_by_zero;
  logic               busy;
  logic               done;

  instruction_t mem [32];
  assign instruction_word = mem[read_pointer];

  instr_exec_unit #(.RESULT_W(64), .DIV0_RESULT(64'sd0)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .base_addr        (base_addr),
    .count            (count),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .result           (result),
    .res_opcode       (res_opcode),
    .res_addr         (res_addr),
    .div_by_zero      (div_by_zero),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [63:0] res;
    opcode_t            opc;
    address_t           addr;
    logic               dbz;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Observations filled in by sb_run
  int first_valid;
  int first_done;
  int done_pulses;
  int gap;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic signed [63:0] r, input opcode_t o,
                      input address_t a, input logic z);
    exp_t e;
    e.res = r; e.opc = o; e.addr = a; e.dbz = z;
    exp_q.push_back(e);
  endtask

  task automatic set_mem(input int idx, input opcode_t o, input int a, input int b);
    mem[idx].opc  = o;
    mem[idx].op_a = a;
    mem[idx].op_b = b;
  endtask

  // Reference arithmetic on 64-bit longints, independent of DUT widths.
  task automatic model(input instruction_t w, output logic signed [63:0] r, output logic z);
    longint a;
    longint b;
    a = longint'(w.op_a);
    b = longint'(w.op_b);
    z = 1'b0;
    case (w.opc)
      ZERO:  r = 0;
      PASSA: r = a;
      PASSB: r = b;
      ADD:   r = a + b;
      SUB:   r = a - b;
      MULT:  r = a * b;
      DIV:   if (b == 0) begin r = 0; z = 1'b1; end else r = a / b;
      MOD:   if (b == 0) begin r = 0; z = 1'b1; end else r = a % b;
      default: r = 0;
    endcase
  endtask

  // Raise start for one sampling edge; returns 1 time unit after that edge.
  task automatic launch(input address_t b, input count_t c);
    start     = 1'b1;
    base_addr = b;
    count     = c;
    tick();
    start     = 1'b0;
  endtask

  // Consume results, holding res_ready low for the first 'stall' valid cycles.
  task automatic sb_run(input int stall, input int budget);
    int                 cyc;
    int                 stall_left;
    int                 hs_edge;
    bit                 holding;
    logic signed [63:0] h_res;
    opcode_t            h_opc;
    address_t           h_addr;
    address_t           h_rp;
    exp_t               e;
    cyc = 0; stall_left = stall; hs_edge = -1; holding = 1'b0;
    first_valid = -1; first_done = -1; done_pulses = 0; gap = -1;
    h_res = '0; h_opc = ZERO; h_addr = '0; h_rp = '0;
    res_ready = 1'b1;
    while (cyc < budget) begin
      if (done) begin
        done_pulses++;
        if (first_done < 0) first_done = cyc;
      end
      if (res_valid) begin
        if (first_valid < 0) first_valid = cyc;
        else if (hs_edge >= 0 && gap < 0) gap = cyc - hs_edge;
        if (holding) begin
          n_cmp++;
          if (result !== h_res || res_opcode !== h_opc || res_addr !== h_addr ||
              read_pointer !== h_rp) begin
            n_err++;
            $display("FAIL hold@%0d: got res=%0d opc=%0d addr=%0d rp=%0d, want res=%0d opc=%0d addr=%0d rp=%0d",
                     cyc, result, res_opcode, res_addr, read_pointer, h_res, h_opc, h_addr, h_rp);
          end
        end else if (stall_left > 0) begin
          h_res = result; h_opc = res_opcode; h_addr = res_addr; h_rp = read_pointer;
          holding = 1'b1;
        end
        if (stall_left > 0) begin
          res_ready = 1'b0;
          stall_left--;
        end else begin
          res_ready = 1'b1;
          holding   = 1'b0;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_result: got res=%0d addr=%0d, want none", result, res_addr);
          end else begin
            e = exp_q.pop_front();
            if (result !== e.res || res_opcode !== e.opc || res_addr !== e.addr ||
                div_by_zero !== e.dbz) begin
              n_err++;
              $display("FAIL result: got res=%0d opc=%0d addr=%0d dbz=%b, want res=%0d opc=%0d addr=%0d dbz=%b",
                       result, res_opcode, res_addr, div_by_zero, e.res, e.opc, e.addr, e.dbz);
            end
          end
          if (hs_edge < 0) hs_edge = cyc + 1;
        end
      end
      if (!busy && exp_q.size() == 0) break;
      tick();
      cyc++;
    end
    res_ready = 1'b1;
    if (cyc >= budget) begin
      n_cmp++; n_err++;
      $display("FAIL timeout: got %0d cycles, want < %0d", cyc, budget);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_results: got %0d left, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; base_addr = '0; count = '0; res_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    n_cmp++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || read_pointer !== 5'h1F) begin
      n_err++;
      $display("FAIL reset_ctrl: got valid=%b busy=%b done=%b rp=%h, want 0 0 0 1f",
               res_valid, busy, done, read_pointer);
    end
    n_cmp++;
    if (result !== 64'sd0 || res_opcode !== ZERO || res_addr !== 5'd0 || div_by_zero !== 1'b0) begin
      n_err++;
      $display("FAIL reset_data: got res=%0d opc=%0d addr=%0d dbz=%b, want 0 0 0 0",
               result, res_opcode, res_addr, div_by_zero);
    end
  endtask

  task automatic test_basic();
    set_mem(0, ADD, 7, -3);
    set_mem(1, MULT, -15, 15);
    set_mem(2, SUB, 0, 9);
    push(64'sd4, ADD, 5'd0, 1'b0);
    push(-64'sd225, MULT, 5'd1, 1'b0);
    push(-64'sd9, SUB, 5'd2, 1'b0);
    launch(5'd0, 6'd3);
    sb_run(0, 40);
    n_cmp++;
    if (first_valid + 1 != 3) begin
      n_err++;
      $display("FAIL first_latency: got %0d, want 3", first_valid + 1);
    end
    n_cmp++;
    if (done_pulses != 1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL basic_done: got pulses=%0d busy=%b, want 1 0", done_pulses, busy);
    end
  endtask

  task automatic test_divmod();
    set_mem(5, DIV, -7, 2);
    set_mem(6, MOD, -7, 2);
    set_mem(7, DIV, 5, 0);
    push(-64'sd3, DIV, 5'd5, 1'b0);
    push(-64'sd1, MOD, 5'd6, 1'b0);
    push(64'sd0, DIV, 5'd7, 1'b1);
    launch(5'd5, 6'd3);
    sb_run(0, 40);
  endtask

  task automatic test_backpressure();
    push(64'sd4, ADD, 5'd0, 1'b0);
    push(-64'sd225, MULT, 5'd1, 1'b0);
    push(-64'sd9, SUB, 5'd2, 1'b0);
    launch(5'd0, 6'd3);
    sb_run(4, 60);
    n_cmp++;
    if (gap != 2) begin
      n_err++;
      $display("FAIL bp_gap: got %0d, want 2", gap);
    end
  endtask

  task automatic test_wrap_busy_start();
    set_mem(30, PASSA, 30, 0);
    set_mem(31, PASSA, 31, 0);
    push(64'sd30, PASSA, 5'd30, 1'b0);
    push(64'sd31, PASSA, 5'd31, 1'b0);
    push(64'sd4, ADD, 5'd0, 1'b0);
    launch(5'd30, 6'd3);
    // Second start arrives while busy and must have no effect.
    launch(5'd5, 6'd3);
    sb_run(0, 40);
    n_cmp++;
    if (done_pulses != 1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_done: got pulses=%0d busy=%b, want 1 0", done_pulses, busy);
    end
  endtask

  task automatic test_count_zero();
    launch(5'd4, 6'd0);
    sb_run(0, 10);
    n_cmp++;
    if (first_done + 1 != 1 || done_pulses != 1 || first_valid != -1) begin
      n_err++;
      $display("FAIL count_zero: got done_at=%0d pulses=%0d valid_at=%0d, want 1 1 -1",
               first_done + 1, done_pulses, first_valid);
    end
  endtask

  task automatic test_clamp();
    logic signed [63:0] r;
    logic               z;
    for (int i = 0; i < 32; i++) begin
      model(mem[(3 + i) % 32], r, z);
      push(r, mem[(3 + i) % 32].opc, address_t'((3 + i) % 32), z);
    end
    launch(5'd3, 6'd40);
    sb_run(0, 200);
    n_cmp++;
    if (done_pulses != 1) begin
      n_err++;
      $display("FAIL clamp_done: got %0d, want 1", done_pulses);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    launch(5'd0, 6'd3);
    res_ready = 1'b0;
    w = 0;
    while (!res_valid && w < 10) begin
      tick();
      w++;
    end
    n_cmp++;
    if (!res_valid) begin
      n_err++;
      $display("FAIL reset_mid_wait: got valid=%b, want 1", res_valid);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    res_ready = 1'b1;
    n_cmp++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || read_pointer !== 5'h1F) begin
      n_err++;
      $display("FAIL reset_mid: got valid=%b busy=%b rp=%h, want 0 0 1f",
               res_valid, busy, read_pointer);
    end
    push(-64'sd3, DIV, 5'd5, 1'b0);
    push(-64'sd1, MOD, 5'd6, 1'b0);
    push(64'sd0, DIV, 5'd7, 1'b1);
    launch(5'd5, 6'd3);
    sb_run(0, 40);
  endtask

  task automatic test_opcode_sweep();
    for (int i = 0; i < 8; i++) set_mem(8 + i, opcode_t'(i), -1, 2147483647);
    push(64'sd0,           ZERO,  5'd8,  1'b0);
    push(-64'sd1,          PASSA, 5'd9,  1'b0);
    push(64'sd2147483647,  PASSB, 5'd10, 1'b0);
    push(64'sd2147483646,  ADD,   5'd11, 1'b0);
    push(-64'sd2147483648, SUB,   5'd12, 1'b0);
    push(-64'sd2147483647, MULT,  5'd13, 1'b0);
    push(64'sd0,           DIV,   5'd14, 1'b0);
    push(-64'sd1,          MOD,   5'd15, 1'b0);
    launch(5'd8, 6'd8);
    sb_run(0, 60);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_divmod();
    test_backpressure();
    test_wrap_busy_start();
    test_count_zero();
    test_reset_mid();
    test_opcode_sweep();
    test_clamp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_instr_exec_unit
`default_nettype wire
